mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequential arbiter that shares the single-ported `memory_io` block between the processor's instruction-fetch path and its load/store path. It sits between the MkII control unit (fetch requester), the datapath (data requester) and `memory_io`. It serialises requests, drives the memory `Address`/`Din`/`R`/`W` strobes for a fixed access latency, and returns read data with a one-cycle acknowledge to the winning requester.

## Interface
- `ADDR_W`, 12, memory address width; matches `memory_io` `Address`.
- `DATA_W`, 32, data word width.
- `MEM_LAT`, 1, cycles `mem_r`/`mem_w` are held before read data is captured; legal range 1..7.

- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request (read only); held until `if_ack`.
- `if_addr`  in  ADDR_W  fetch address; stable while `if_req` is high.
- `if_rdata`  out  DATA_W  fetched word; valid in the `if_ack` cycle and held afterwards.
- `if_ack`  out  1  one-cycle completion pulse for fetch.
- `d_req`  in  1  data request; held until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_rdata`  out  DATA_W  loaded word; valid in the `d_ack` cycle and held afterwards.
- `d_ack`  out  1  one-cycle completion pulse for data.
- `mem_addr`  out  ADDR_W  to `memory_io.Address`.
- `mem_din`  out  DATA_W  to `memory_io.Din`.
- `mem_dout`  in  DATA_W  from `memory_io.Dout`.
- `mem_r`, `mem_w`  out  1  read/write strobes to `memory_io`; never high together.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE: requests are sampled only here.
  - ACCESS: 3-bit counter runs from 0 to MEM_LAT-1.
  - DONE: ack is issued.
- IDLE, no request: remain in IDLE; all strobes low.
- IDLE, request present:
  - Select a winner.
  - Register the winner ID, `mem_addr` and `mem_din` (fetch: `mem_din` is unchanged).
  - Clear the counter and go to ACCESS.
- ACCESS:
  - `mem_r` is high for a fetch or a load; `mem_w` is high for a store.
  - When the counter reaches MEM_LAT-1, capture `mem_dout` into the winner's rdata register (loads and fetches only) and go to DONE.
- DONE:
  - The winner's ack is high for exactly this cycle; strobes are low.
  - Return to IDLE.
  - Requests present in DONE are not sampled.
- Arbitration when both requests are high in IDLE is fixed priority, data over fetch (see Configuration).
- Stores never modify `d_rdata`. The losing requester's outputs are unchanged.
- `mem_addr` and `mem_din` hold their last granted values while in IDLE.
- Requests dropped before ack are a protocol violation. The access completes regardless, and the ack is still pulsed.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE and the counter to 0.
  - All outputs go to 0: `if_rdata`, `d_rdata`, `if_ack`, `d_ack`, `mem_addr`, `mem_din`, `mem_r`, `mem_w`, `busy`.
  - An in-flight access is abandoned; no ack is ever issued for it.
- Latency, with the request sampled at edge 0:
  - Strobes are high in cycles 1..MEM_LAT.
  - Ack is high in cycle MEM_LAT+1.
  - `busy` is high in cycles 1..MEM_LAT+1.
- Throughput: one access per MEM_LAT+2 cycles. A request held continuously is re-granted at the edge leaving DONE+1 (that is, from IDLE).
- `mem_addr`/`mem_din` change only on a grant edge and are stable for the whole strobe window.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - A 1-bit last-granted flag (reset value = data) selects the winner on contention: the requester not granted last wins.
  - The flag updates on every grant.
  - First contention after reset goes to fetch.
- Undefined: fixed priority, data always wins; the flag is not built.

## Test plan
- Reset, with all inputs random → every output 0. Assert `reset` during ACCESS → outputs drop to 0 asynchronously; no ack follows after release.
- MEM_LAT=1, `if_req` with `if_addr`=0x010 and `mem_dout`=0x00100413 → `mem_r`=1 and `mem_addr`=0x010 in cycle 1; `if_ack`=1 and `if_rdata`=0x00100413 in cycle 2; `d_ack` stays 0.
- MEM_LAT=1, store with `d_addr`=0x020 and `d_wdata`=0xDEADBEEF → `mem_w`=1, `mem_addr`=0x020, `mem_din`=0xDEADBEEF in cycle 1; `mem_r`=0 throughout; `d_ack` in cycle 2; `d_rdata` unchanged.
- Simultaneous `if_req` and `d_req` (load at 0x004), both held:
  - Without the macro → `d_ack` first (cycle 2), then `if_ack` (cycle 5).
  - With `MEM_ARB_ROUND_ROBIN_EN` → `if_ack` first, then `d_ack`.
- MEM_LAT=3, load from `d_addr`=0x0FF with `mem_dout`=0x000FF9B7 → `mem_r` high in cycles 1..3; `d_ack` in cycle 4 with `d_rdata`=0x000FF9B7; `busy` high in cycles 1..4.
- Back-to-back fetches with `if_req` held, MEM_LAT=1 → acks in cycles 2, 5 and 8; no strobe in any DONE cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported memory between the instruction-fetch requester and
// the load/store requester. Requests are sampled only in IDLE. The winner's
// address/data are registered and driven to memory with the read or write
// strobe held for MEM_LAT cycles. In the following cycle the winner receives a
// one-cycle ack; for reads, its rdata register is updated in that same cycle.
//
// Parameters:
//   ADDR_W   memory address width
//   DATA_W   data word width
//   MEM_LAT  strobe length in cycles before read data is captured (1..7)
//
// Ports:
//   clock, reset           single clock; asynchronous active-high reset
//   if_req/if_addr         fetch request (read only) and address
//   if_rdata/if_ack        fetched word (held) and one-cycle completion pulse
//   d_req/d_we/d_addr      data request, 1 = store, address
//   d_wdata                store data
//   d_rdata/d_ack          loaded word (held) and one-cycle completion pulse
//   mem_addr/mem_din       registered address/write data to the memory
//   mem_dout               read data from the memory
//   mem_r/mem_w            read/write strobes, mutually exclusive
//   busy                   high whenever the arbiter is not idle
//
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN  when defined, contention alternates between the
//                           two requesters (first contention after reset goes
//                           to fetch); otherwise data always wins.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              mem_r,
  output logic              mem_w,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Counter value on the final strobe cycle.
  localparam logic [2:0] LAST_CNT = 3'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              win_data_q, win_data_d;   // 1 = data port owns the access
  logic              store_q, store_d;         // current access is a write
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic grant_evt;    // a request is accepted on this edge
  logic grant_data;   // arbitration result: 1 = data, 0 = fetch

  assign grant_evt = (state_q == ST_IDLE) & (if_req | d_req);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Last-granted flag: 1 = data. Resetting to data hands the first
  // contention to fetch.
  logic last_data_q, last_data_d;

  // Data wins when alone, or on contention when fetch was granted last.
  assign grant_data = d_req & (~if_req | ~last_data_q);

  always_comb begin
    last_data_d = last_data_q;
    if (grant_evt) begin
      last_data_d = grant_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_data_q <= 1'b1;
    end else begin
      last_data_q <= last_data_d;
    end
  end
`else
  // Fixed priority: data over fetch.
  assign grant_data = d_req;
`endif

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    win_data_d = win_data_q;
    store_d    = store_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    mem_r      = 1'b0;
    mem_w      = 1'b0;
    if_ack     = 1'b0;
    d_ack      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_evt) begin
          win_data_d = grant_data;
          store_d    = grant_data & d_we;
          mem_addr_d = grant_data ? d_addr : if_addr;
          // A fetch leaves the write-data bus at its previous value.
          if (grant_data) begin
            mem_din_d = d_wdata;
          end
          cnt_d   = '0;
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        mem_r = ~store_q;
        mem_w = store_q;
        if (cnt_q == LAST_CNT) begin
          // Stores leave both rdata registers untouched.
          if (!store_q) begin
            if (win_data_q) begin
              d_rdata_d = mem_dout;
            end else begin
              if_rdata_d = mem_dout;
            end
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      ST_DONE: begin
        if_ack  = ~win_data_q;
        d_ack   = win_data_q;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      win_data_q <= 1'b0;
      store_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      win_data_q <= win_data_d;
      store_q    <= store_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
